bus_trace_buffer: RTL

- Captures the processor bus word (BusWires) on every rising edge of Done into a DEPTH-entry circular history.
- Lets the operator freeze the history and step through it with two push-buttons.
- Sits downstream of the processor and upstream of the hexto7segment decoders: ShowWord drives HEX0–HEX3, ShowIdx and Count drive the spare digits.

---
 rtl/bus_trace_buffer_pkg.sv | 22 ++
 rtl/bus_trace_buffer_if.sv | 39 +++
 rtl/bus_trace_buffer_sync_edge.sv | 39 +++
 rtl/bus_trace_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_trace_buffer_pkg.sv
// ---------------------------------------------------------------------------
// bus_trace_buffer_pkg
// Shared definitions for the bus trace buffer: default geometry and the
// two-state controller encoding (LIVE = capturing, FROZEN = browsing).
// No ports.
// ---------------------------------------------------------------------------
package bus_trace_buffer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic [0:0] {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } trace_state_e;

  // Plain constants of the same encoding, for legacy-style state registers
  localparam logic [0:0] ST_LIVE   = 1'b0;
  localparam logic [0:0] ST_FROZEN = 1'b1;

endpackage

// File: rtl/bus_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// bus_trace_buffer_if
// Groups the processor-side inputs, operator controls and display outputs of
// the trace buffer.
//   BusWires, Done          : processor bus word and instruction-complete flag
//   Freeze, Next, Prev      : operator switch and push-buttons (asynchronous)
//   ShowWord, ShowIdx       : displayed word and its age (0 = newest)
//   Count, Overflow, Frozen : number of valid entries, sticky wrap flag, mode
// Modport slave is the buffer; modport master is whoever drives it.
// ---------------------------------------------------------------------------
interface bus_trace_buffer_if
  import bus_trace_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic [WIDTH-1:0] BusWires;
  logic             Done;
  logic             Freeze;
  logic             Next;
  logic             Prev;
  logic [WIDTH-1:0] ShowWord;
  logic [AW-1:0]    ShowIdx;
  logic [AW:0]      Count;
  logic             Frozen;
  logic             Overflow;

  modport slave (
    input  BusWires, Done, Freeze, Next, Prev,
    output ShowWord, ShowIdx, Count, Frozen, Overflow
  );

  modport master (
    output BusWires, Done, Freeze, Next, Prev,
    input  ShowWord, ShowIdx, Count, Frozen, Overflow
  );

endinterface

// File: rtl/bus_trace_buffer_sync_edge.sv
// ---------------------------------------------------------------------------
// bus_trace_buffer_sync_edge
// Two-flop synchronizer for an asynchronous operator input, followed by a
// rising-edge detector so one press yields one single-cycle pulse.
//   i_clk   : system clock
//   i_rstn  : synchronous reset, active-low
//   i_async : asynchronous input
//   o_level : synchronized level
//   o_rise  : one-cycle pulse on a synchronized rising edge
// ---------------------------------------------------------------------------
module bus_trace_buffer_sync_edge (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_sync_q;

endmodule

// File: rtl/bus_trace_buffer.sv
// ---------------------------------------------------------------------------
// bus_trace_buffer
// Records the processor bus word on every rising edge of Done into a
// DEPTH-entry circular history. The operator can freeze the history and step
// through it with Next (older) / Prev (newer).
//   Clock  : system clock, rising edge
//   Resetn : synchronous reset, active-low
//   bus    : slave side of bus_trace_buffer_if (inputs BusWires, Done,
//            Freeze, Next, Prev; registered outputs ShowWord, ShowIdx,
//            Count, Frozen, Overflow)
// ---------------------------------------------------------------------------
module bus_trace_buffer
  import bus_trace_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input logic               Clock,
  input logic               Resetn,
  bus_trace_buffer_if.slave bus
);

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    r_age;
  logic             r_overflow;
  logic [0:0]       r_state;
  logic             r_done_q;
  logic [WIDTH-1:0] r_show_word;
  logic [AW-1:0]    r_show_idx;
  logic             r_frozen;

  logic             w_freeze_s;
  logic             w_unused_freeze_rise;
  logic             w_next_rise;
  logic             w_unused_next_level;
  logic             w_prev_rise;
  logic             w_unused_prev_level;
  logic             w_done_rise;
  logic             w_cap;
  logic [0:0]       w_state_nxt;
  logic [AW-1:0]    w_age_nxt;
  logic [AW-1:0]    w_rd_addr;

  bus_trace_buffer_sync_edge u_sync_freeze (
    .i_clk   (Clock),
    .i_rstn  (Resetn),
    .i_async (bus.Freeze),
    .o_level (w_freeze_s),
    .o_rise  (w_unused_freeze_rise)
  );

  bus_trace_buffer_sync_edge u_sync_next (
    .i_clk   (Clock),
    .i_rstn  (Resetn),
    .i_async (bus.Next),
    .o_level (w_unused_next_level),
    .o_rise  (w_next_rise)
  );

  bus_trace_buffer_sync_edge u_sync_prev (
    .i_clk   (Clock),
    .i_rstn  (Resetn),
    .i_async (bus.Prev),
    .o_level (w_unused_prev_level),
    .o_rise  (w_prev_rise)
  );

  // Done is already synchronous; only its rising edge matters, so a long
  // Done level produces a single capture. Freeze suppresses capture in the
  // very cycle it is seen, before the state register has moved.
  assign w_done_rise = bus.Done & ~r_done_q;
  assign w_cap       = w_done_rise & (r_state == ST_LIVE) & ~w_freeze_s;

  // Newest entry sits at wr_ptr-1; age counts backwards from there, wrapping
  assign w_rd_addr = r_wr_ptr - PTR_ONE - r_age;

  // Two-state controller: follow the synchronized Freeze switch
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LIVE: begin
        if (w_freeze_s) begin
          w_state_nxt = ST_FROZEN;
        end else begin
          w_state_nxt = ST_LIVE;
        end
      end
      ST_FROZEN: begin
        if (!w_freeze_s) begin
          w_state_nxt = ST_LIVE;
        end else begin
          w_state_nxt = ST_FROZEN;
        end
      end
      default: w_state_nxt = ST_LIVE;
    endcase
  end

  // Browse position: held at 0 while live, clamped to [0, Count-1] when frozen;
  // simultaneous Next and Prev cancel out
  always_comb begin
    w_age_nxt = r_age;
    if (r_state == ST_LIVE) begin
      w_age_nxt = PTR_ZERO;
    end else if (w_next_rise && !w_prev_rise) begin
      if (({1'b0, r_age} + CNT_ONE) < r_count) begin
        w_age_nxt = r_age + PTR_ONE;
      end else begin
        w_age_nxt = r_age;
      end
    end else if (w_prev_rise && !w_next_rise) begin
      if (r_age != PTR_ZERO) begin
        w_age_nxt = r_age - PTR_ONE;
      end else begin
        w_age_nxt = r_age;
      end
    end else begin
      w_age_nxt = r_age;
    end
  end

  // History storage; deliberately not reset, Count=0 hides stale contents
  always_ff @(posedge Clock) begin
    if (w_cap) begin
      r_mem[r_wr_ptr] <= bus.BusWires;
    end
  end

  // Control state, pointers, counters and registered display outputs
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_wr_ptr    <= PTR_ZERO;
      r_count     <= CNT_ZERO;
      r_age       <= PTR_ZERO;
      r_overflow  <= 1'b0;
      r_state     <= ST_LIVE;
      r_done_q    <= 1'b0;
      r_show_word <= {WIDTH{1'b0}};
      r_show_idx  <= PTR_ZERO;
      r_frozen    <= 1'b0;
    end else begin
      r_done_q <= bus.Done;
      r_state  <= w_state_nxt;
      r_age    <= w_age_nxt;
      r_frozen <= (w_state_nxt == ST_FROZEN);

      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_count == CNT_FULL) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end

      if (r_state == ST_LIVE) begin
        r_show_word <= bus.BusWires;
        r_show_idx  <= PTR_ZERO;
      end else if (r_count != CNT_ZERO) begin
        r_show_word <= r_mem[w_rd_addr];
        r_show_idx  <= r_age;
      end else begin
        r_show_word <= {WIDTH{1'b0}};
        r_show_idx  <= r_age;
      end
    end
  end

  assign bus.ShowWord = r_show_word;
  assign bus.ShowIdx  = r_show_idx;
  assign bus.Count    = r_count;
  assign bus.Frozen   = r_frozen;
  assign bus.Overflow = r_overflow;

endmodule
